puf_response_stabilizer: RTL and testbench
==========================================

# puf_response_stabilizer

Majority-vote stage directly downstream of the multi-bit PUF core inside `tt_um_multi_bit_puf_wrapper`. On a start command it requests `SAMPLES` back-to-back evaluations from the PUF core and counts ones per response bit. It then publishes a majority-voted stable response plus a per-bit instability mask to the output pins. A per-evaluation timeout guards against a stalled core.

## Interface

Parameters:
- `WIDTH`, 8, PUF response width in bits.
- `SAMPLES`, 7, evaluations per vote; odd, legal range 3..15.
- `TIMEOUT`, 255, maximum cycles to wait for one `puf_valid`; legal range 1..255.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `start` in 1 — request a stabilized response; level-sampled each edge.
- `puf_req` out 1 — one-cycle pulse asking the PUF core for one evaluation.
- `puf_valid` in 1 — PUF core response qualifier.
- `puf_resp` in WIDTH — raw PUF response, valid when `puf_valid`=1.
- `busy` out 1 — high in every state except IDLE and DONE.
- `resp_valid` out 1 — `resp_out`/`unstable` hold a completed vote.
- `resp_out` out WIDTH — majority-voted response.
- `unstable` out WIDTH — bit i = 1 if the samples of bit i were not unanimous.
- `timeout_err` out 1 — last run aborted on timeout.

## Operation

- States:
  - IDLE: reset state.
  - REQ: `puf_req`=1 for exactly this cycle.
  - WAIT: await `puf_valid`.
  - VOTE: one cycle; computes the result.
  - DONE: result held.
- Transitions:
  - IDLE/DONE —`start`→ REQ. This edge also clears the ones counters, sample counter, `resp_valid`, `timeout_err`, `resp_out` and `unstable`.
  - REQ → WAIT unconditionally. The wait counter is cleared on entry.
  - WAIT with `puf_valid`: accumulate the sample, then go to VOTE if the sample count reaches `SAMPLES`, else back to REQ.
  - WAIT without `puf_valid`: increment the wait counter. On reaching `TIMEOUT`, go to IDLE with `timeout_err`=1.
  - VOTE → DONE, registering the result.
- Accumulation: per bit, a counter of width clog2(SAMPLES+1) increments when `puf_resp[i]`=1; it never wraps for legal `SAMPLES`.
- Vote rules:
  - `resp_out[i]` = (ones[i] >= (SAMPLES+1)/2).
  - `unstable[i]` = (ones[i] != 0 && ones[i] != SAMPLES).
- Ignored inputs:
  - `start` is ignored while `busy`=1.
  - `puf_valid` outside WAIT is ignored and not counted, including in the REQ cycle.
- Held outputs: `resp_out`/`unstable` hold in DONE indefinitely and remain 0 after a timeout abort.
- Reset values: every output is 0 and the state is IDLE. Reset mid-run discards all partial counts immediately, without waiting for a clock edge.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- `start` sampled high at edge S:
  - REQ occupies cycle S..S+1.
  - The earliest sample is accepted at edge S+2.
- Each evaluation takes 2 cycles plus the PUF latency. With zero-wait responses the last sample is accepted at edge S+2·SAMPLES.
- VOTE executes in the following cycle. `resp_valid` rises at edge S+2·SAMPLES+1, which is edge S+15 for the defaults.
- Timeout:
  - `timeout_err` rises at the edge on which the wait counter reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after WAIT entry with no `puf_valid`.
  - `busy` falls at that same edge.
- `busy` rises at the edge that samples `start` and falls at the edge entering DONE or IDLE.
- `start` held high in DONE restarts on every entry to DONE. A bench must drop `start` after one cycle to observe a held result.

## Test plan

- Constant 0x3C on all 7 samples, zero wait → `resp_out`=0x3C, `unstable`=0x00, `resp_valid` at edge S+15, exactly 7 `puf_req` pulses.
- Samples 0xA5 ×4 then 0x5A ×3 → `resp_out`=0xA5, `unstable`=0xFF.
- Random `puf_valid` delays of 0–10 cycles plus spurious `puf_valid` during REQ/IDLE → result unchanged from the zero-wait case, exactly 7 samples counted.
- `TIMEOUT`=20, PUF never answers → `timeout_err`=1, `busy`=0, `resp_valid`=0 at 20 cycles after WAIT entry. A following `start` clears `timeout_err` and completes normally.
- `start` re-pulsed during WAIT → ignored: same result, no extra `puf_req`. `start` in DONE → `resp_valid` drops at the next edge and a new run begins.
- `rst_n` low after the third sample → all outputs 0 immediately. After release plus `start`, a full 7-sample run gives correct counts with no carry-over.

Source files
------------

// File: rtl/puf_response_stabilizer_if.sv
// Handshake and result bundle between the PUF majority-vote stabilizer,
// the PUF core it drives, and the consumer of the stabilized response.
interface puf_response_stabilizer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             puf_req;
    logic             puf_valid;
    logic [WIDTH-1:0] puf_resp;
    logic             busy;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_out;
    logic [WIDTH-1:0] unstable;
    logic             timeout_err;

    // Stabilizer side
    modport slave (
        input  start, puf_valid, puf_resp,
        output puf_req, busy, resp_valid, resp_out, unstable, timeout_err
    );

    // Requester / PUF-core side
    modport master (
        output start, puf_valid, puf_resp,
        input  puf_req, busy, resp_valid, resp_out, unstable, timeout_err
    );
endinterface

// File: rtl/puf_response_stabilizer.sv
// Majority-vote stabilizer for a multi-bit PUF: requests SAMPLES evaluations,
// counts ones per bit, then publishes the voted response and a mask of bits
// whose samples disagreed. A per-evaluation timeout aborts a stalled run.
module puf_response_stabilizer #(
    parameter int WIDTH   = 8,
    parameter int SAMPLES = 7,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    puf_response_stabilizer_if.slave bus
);
    localparam int CW = $clog2(SAMPLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAJ = CW'((SAMPLES + 1) / 2);
    localparam logic [CW-1:0] ALL = CW'(SAMPLES);
    localparam logic [WW-1:0] TMO = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VOTE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ones_q [WIDTH];
    logic [CW-1:0]     ones_d [WIDTH];
    logic [CW-1:0]     sample_cnt_q, sample_cnt_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              puf_req_q, puf_req_d;
    logic              busy_q, busy_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]  resp_out_q, resp_out_d;
    logic [WIDTH-1:0]  unstable_q, unstable_d;
    logic              timeout_err_q, timeout_err_d;

    logic              last_sample;
    logic              timeout_hit;

    // The sample being accepted now is the final one of the vote
    assign last_sample = (sample_cnt_q + CW'(1)) == ALL;
    // This WAIT cycle is the one that exhausts the timeout budget
    assign timeout_hit = (wait_cnt_q + WW'(1)) == TMO;

    // State and datapath registers; reset discards partial counts at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sample_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            puf_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_out_q    <= '0;
            unstable_q    <= '0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                ones_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            puf_req_q     <= puf_req_d;
            busy_q        <= busy_d;
            resp_valid_q  <= resp_valid_d;
            resp_out_q    <= resp_out_d;
            unstable_q    <= unstable_d;
            timeout_err_q <= timeout_err_d;
            for (int i = 0; i < WIDTH; i++) begin
                ones_q[i] <= ones_d[i];
            end
        end
    end

    // Next-state: start only honoured when not busy, puf_valid only in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) state_d = S_REQ;
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.puf_valid) begin
                    state_d = last_sample ? S_VOTE : S_REQ;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_VOTE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, vote and registered outputs, all derived from state and next state
    always_comb begin
        sample_cnt_d  = sample_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        resp_valid_d  = resp_valid_q;
        resp_out_d    = resp_out_q;
        unstable_d    = unstable_q;
        timeout_err_d = timeout_err_q;
        for (int i = 0; i < WIDTH; i++) begin
            ones_d[i] = ones_q[i];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sample_cnt_d  = '0;
                    resp_valid_d  = 1'b0;
                    resp_out_d    = '0;
                    unstable_d    = '0;
                    timeout_err_d = 1'b0;
                    for (int i = 0; i < WIDTH; i++) begin
                        ones_d[i] = '0;
                    end
                end
            end
            S_REQ: begin
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (bus.puf_valid) begin
                    sample_cnt_d = sample_cnt_q + CW'(1);
                    for (int i = 0; i < WIDTH; i++) begin
                        ones_d[i] = ones_q[i] + {{(CW-1){1'b0}}, bus.puf_resp[i]};
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                    if (timeout_hit) timeout_err_d = 1'b1;
                end
            end
            S_VOTE: begin
                resp_valid_d = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    resp_out_d[i] = ones_q[i] >= MAJ;
                    unstable_d[i] = (ones_q[i] != '0) && (ones_q[i] != ALL);
                end
            end
            default: ;
        endcase

        puf_req_d = (state_d == S_REQ);
        busy_d    = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_VOTE);
    end

    assign bus.puf_req     = puf_req_q;
    assign bus.busy        = busy_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_out    = resp_out_q;
    assign bus.unstable    = unstable_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_puf_response_stabilizer.sv
// Bench for puf_response_stabilizer: a behavioural PUF core answers each
// request with a scripted sample after a chosen delay, and results are
// compared against a table of hand-derived vectors and a counting model.
module tb_puf_response_stabilizer;
    localparam int W   = 8;
    localparam int NS  = 7;
    localparam int TMO = 20;

    typedef logic [NS-1:0][W-1:0] smp_t;
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] n;
        logic       dly;
        logic       spur;
        logic [7:0] er;
        logic [7:0] eu;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puf_response_stabilizer_if #(.WIDTH(W)) bif ();

    puf_response_stabilizer #(
        .WIDTH  (W),
        .SAMPLES(NS),
        .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    smp_t sample_vec;
    int   sample_idx = 0;
    int   req_count  = 0;
    bit   delay_mode = 0;
    bit   spurious   = 0;
    bit   mute       = 0;
    bit   pending;
    int   cnt_down;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: count ones per bit over the sample list, then vote
    function automatic void model(input smp_t smp, output logic [7:0] r, output logic [7:0] u);
        for (int b = 0; b < W; b++) begin
            int ones = 0;
            for (int s = 0; s < NS; s++) ones += int'(smp[s][b]);
            r[b] = (2 * ones > NS);
            u[b] = (ones > 0) && (ones < NS);
        end
    endfunction

    // Behavioural PUF core, driven on the falling edge
    initial begin
        bif.puf_valid = 1'b0;
        bif.puf_resp  = '0;
        pending  = 0;
        cnt_down = 0;
        forever begin
            @(negedge clk);
            bif.puf_valid = 1'b0;
            bif.puf_resp  = W'($urandom);
            if (!bif.busy) pending = 0;
            if (pending) begin
                if (cnt_down == 0) begin
                    bif.puf_valid = 1'b1;
                    bif.puf_resp  = (sample_idx < NS) ? sample_vec[sample_idx] : '0;
                    sample_idx++;
                    pending = 0;
                end else begin
                    cnt_down--;
                end
            end
            if (bif.puf_req) begin
                req_count++;
                if (!mute) begin
                    pending  = 1;
                    cnt_down = delay_mode ? int'($urandom_range(0, 10)) : 0;
                end
                if (spurious && $urandom_range(0, 1) == 1) bif.puf_valid = 1'b1;
            end else if (spurious && !bif.busy && $urandom_range(0, 3) == 0) begin
                bif.puf_valid = 1'b1;
            end
        end
    end

    task automatic run_vote(input smp_t smp, input bit dly, input bit spur, input bit repulse,
                            output logic [7:0] r, output logic [7:0] u, output int lat);
        int s_cyc;
        bit done;
        sample_vec = smp;
        sample_idx = 0;
        delay_mode = dly;
        spurious   = spur;
        req_count  = 0;
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        s_cyc = cyc;
        done  = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (bif.resp_valid) begin
                done = 1;
            end else begin
                @(negedge clk);
                bif.start = repulse && (k == 3 || k == 8);
            end
        end
        bif.start = 1'b0;
        lat = cyc - s_cyc;
        r   = bif.resp_out;
        u   = bif.unstable;
        check("vote_completed", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

    initial begin
        smp_t       s;
        logic [7:0] r, u, er, eu;
        int         lat;
        bit         seen;
        int         s_cyc;
        vec_t       tbl [8];

        bif.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",        32'(bif.busy),        32'd0);
        check("rst_puf_req",     32'(bif.puf_req),     32'd0);
        check("rst_resp_valid",  32'(bif.resp_valid),  32'd0);
        check("rst_resp_out",    32'(bif.resp_out),    32'd0);
        check("rst_unstable",    32'(bif.unstable),    32'd0);
        check("rst_timeout_err", 32'(bif.timeout_err), 32'd0);
        rst_n = 1'b1;

        //             a      b      n     dly   spur  resp   unstable
        tbl[0] = '{8'h3C, 8'h3C, 4'd7, 1'b0, 1'b0, 8'h3C, 8'h00};
        tbl[1] = '{8'hA5, 8'h5A, 4'd4, 1'b0, 1'b0, 8'hA5, 8'hFF};
        tbl[2] = '{8'hFF, 8'hFF, 4'd7, 1'b0, 1'b0, 8'hFF, 8'h00};
        tbl[3] = '{8'h00, 8'h00, 4'd7, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{8'h01, 8'h00, 4'd3, 1'b0, 1'b0, 8'h00, 8'h01};
        tbl[5] = '{8'h80, 8'h00, 4'd4, 1'b0, 1'b0, 8'h80, 8'h80};
        tbl[6] = '{8'h3C, 8'h3C, 4'd7, 1'b1, 1'b1, 8'h3C, 8'h00};
        tbl[7] = '{8'hA5, 8'h5A, 4'd4, 1'b1, 1'b1, 8'hA5, 8'hFF};

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NS; k++) s[k] = (k < int'(tbl[i].n)) ? tbl[i].a : tbl[i].b;
            run_vote(s, tbl[i].dly, tbl[i].spur, 1'b0, r, u, lat);
            check($sformatf("tbl%0d_resp", i),     32'(r),          32'(tbl[i].er));
            check($sformatf("tbl%0d_unstable", i), 32'(u),          32'(tbl[i].eu));
            check($sformatf("tbl%0d_reqs", i),     32'(req_count),  32'(NS));
            check($sformatf("tbl%0d_samples", i),  32'(sample_idx), 32'(NS));
            if (!tbl[i].dly) check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(2 * NS + 1));
            repeat (5) @(negedge clk);
            check($sformatf("tbl%0d_hold_valid", i), 32'(bif.resp_valid), 32'd1);
            check($sformatf("tbl%0d_hold_resp", i),  32'(bif.resp_out),   32'(tbl[i].er));
            check($sformatf("tbl%0d_hold_busy", i),  32'(bif.busy),       32'd0);
        end
        spurious = 0;

        // Random samples with random delays and spurious valids
        for (int it = 0; it < 10; it++) begin
            logic [7:0] base;
            base = 8'($urandom);
            for (int k = 0; k < NS; k++) begin
                s[k] = ($urandom_range(0, 2) == 0) ? (base ^ 8'($urandom)) : base;
            end
            model(s, er, eu);
            run_vote(s, 1'b1, 1'b1, 1'b0, r, u, lat);
            check($sformatf("rnd%0d_resp", it),     32'(r),          32'(er));
            check($sformatf("rnd%0d_unstable", it), 32'(u),          32'(eu));
            check($sformatf("rnd%0d_samples", it),  32'(sample_idx), 32'(NS));
        end
        spurious = 0;

        // start re-pulsed while busy is ignored
        for (int k = 0; k < NS; k++) s[k] = (k < 4) ? 8'hA5 : 8'h5A;
        run_vote(s, 1'b0, 1'b0, 1'b1, r, u, lat);
        check("repulse_resp",     32'(r),         32'hA5);
        check("repulse_unstable", 32'(u),         32'hFF);
        check("repulse_reqs",     32'(req_count), 32'(NS));
        check("repulse_latency",  32'(lat),       32'(2 * NS + 1));

        // start in DONE drops resp_valid and launches a fresh run
        for (int k = 0; k < NS; k++) sample_vec[k] = 8'h0F;
        sample_idx = 0;
        req_count  = 0;
        delay_mode = 0;
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        check("restart_valid_drop", 32'(bif.resp_valid), 32'd0);
        check("restart_busy",       32'(bif.busy),       32'd1);
        check("restart_resp_clear", 32'(bif.resp_out),   32'd0);
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (bif.resp_valid) seen = 1;
            else @(negedge clk);
        end
        check("restart_done", 32'(seen),         32'd1);
        check("restart_resp", 32'(bif.resp_out), 32'h0F);
        check("restart_reqs", 32'(req_count),    32'(NS));

        // PUF core never answers: timeout abort
        mute      = 1;
        req_count = 0;
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        s_cyc = cyc;
        while (cyc < s_cyc + TMO) @(negedge clk);
        check("tmo_before_err",  32'(bif.timeout_err), 32'd0);
        check("tmo_before_busy", 32'(bif.busy),        32'd1);
        @(negedge clk);
        check("tmo_err",         32'(bif.timeout_err), 32'd1);
        check("tmo_busy",        32'(bif.busy),        32'd0);
        check("tmo_resp_valid",  32'(bif.resp_valid),  32'd0);
        check("tmo_resp_out",    32'(bif.resp_out),    32'd0);
        check("tmo_unstable",    32'(bif.unstable),    32'd0);
        check("tmo_reqs",        32'(req_count),       32'd1);
        mute = 0;
        for (int k = 0; k < NS; k++) s[k] = 8'h96;
        run_vote(s, 1'b0, 1'b0, 1'b0, r, u, lat);
        check("post_tmo_err",      32'(bif.timeout_err), 32'd0);
        check("post_tmo_resp",     32'(r),               32'h96);
        check("post_tmo_unstable", 32'(u),               32'h00);
        check("post_tmo_latency",  32'(lat),             32'(2 * NS + 1));

        // Asynchronous reset after the third accepted sample
        for (int k = 0; k < NS; k++) sample_vec[k] = 8'hFF;
        sample_idx = 0;
        delay_mode = 0;
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        for (int k = 0; k < 100 && sample_idx < 3; k++) @(negedge clk);
        check("mid_three_delivered", 32'(sample_idx), 32'd3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy",        32'(bif.busy),        32'd0);
        check("arst_puf_req",     32'(bif.puf_req),     32'd0);
        check("arst_resp_valid",  32'(bif.resp_valid),  32'd0);
        check("arst_resp_out",    32'(bif.resp_out),    32'd0);
        check("arst_unstable",    32'(bif.unstable),    32'd0);
        check("arst_timeout_err", 32'(bif.timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NS; k++) s[k] = (k < 4) ? 8'h0F : 8'h00;
        run_vote(s, 1'b0, 1'b0, 1'b0, r, u, lat);
        check("post_rst_resp",     32'(r),         32'h0F);
        check("post_rst_unstable", 32'(u),         32'h0F);
        check("post_rst_reqs",     32'(req_count), 32'(NS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
